clock_fnd_ctrl: RTL and testbench
=================================

Name: clock_fnd_ctrl

Overview:
- Downstream display stage of the clock datapath. Consumes the binary msec/sec/min/hour counter values.
- Converts the selected field pair to BCD and drives a 4-digit, common-anode, time-multiplexed 7-segment (FND) display.
- Decimal point on digit 2 blinks at 1 Hz as the field separator, derived from msec.
- Sits between the clock datapath and the board FND pins.

Parameters:
- SCAN_COUNT, 100000: clk cycles per digit slot (1 kHz digit rate at 100 MHz).
- BLINK_THRESH, 50: separator dp is lit while msec < BLINK_THRESH.

Ports:
- clk       input   1  system clock
- rst       input   1  asynchronous, active-low reset (0 = reset)
- sel_mode  input   1  0: show sec.msec; 1: show hour.min
- msec      input   7  0..99
- sec       input   6  0..59
- min       input   6  0..59
- hour      input   5  0..23
- fnd_com   output  4  digit enables, active-low; bit0 = rightmost digit
- fnd_data  output  8  segments, active-low; bit7 = dp, bits6..0 = g..a

Behaviour:
- Reset (rst=0, async):
  - scan_cnt=0, digit_sel=0.
  - fnd_com=4'b1111 (all digits off), fnd_data=8'hFF.
  - Reset asserted mid-scan blanks the display immediately; scanning restarts at digit 0.
- Scan counter:
  - scan_cnt counts 0..SCAN_COUNT-1 and wraps to 0.
  - At the wrap, digit_sel increments 0,1,2,3,0.
- Field selection:
  - sel_mode=0: low field = msec, high field = sec.
  - sel_mode=1: low field = min, high field = hour.
  - sel_mode is sampled every cycle; a change takes effect at the next output register update. No glitch suppression is required.
- Digit mapping:
  - d0 = low ones, d1 = low tens.
  - d2 = high ones, d3 = high tens.
  - tens = v/10, ones = v%10, computed combinationally on the 7-bit zero-extended value.
- Range check: a field above its maximum (msec>99, sec>59, min>59, hour>23) displays dash (bits6..0 = 7'h3F) on both of its digits.
- Segment codes, bits6..0:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - dash = 3F.
- Decimal point: fnd_data[7]=0 only when digit_sel==2 and msec<BLINK_THRESH, in both modes; otherwise 1.
- Outputs:
  - fnd_com and fnd_data are registered.
  - Each cycle they reflect digit_sel and inputs from the previous cycle: one-cycle latency.
  - fnd_com has exactly one bit low, fnd_com = ~(4'b0001<<digit_sel), except during reset.
  - First cycle after reset release: fnd_com=4'b1110.
- No leading-zero blanking: hour 5 shows "05".

Decomposition:
- Shared clock package:
  - Segment constants SEG_0..SEG_9 and SEG_DASH.
  - DP bit index (7).
  - Default SCAN_COUNT.
  - Per-field maxima (99, 59, 59, 23).
- One sub-module, clock_fnd_decoder: combinational 4-bit BCD (or dash flag) to 7-bit active-low segment pattern. Instantiated once on the muxed digit.
- The binary-to-BCD split stays inline.

Test Plan (SCAN_COUNT=4 in sim; every check samples one cycle after digit_sel changes):
- Reset: hold rst=0 -> fnd_com=1111, fnd_data=FF. Release -> next cycle fnd_com=1110, and digit_sel advances every 4 clocks through 1101, 1011, 0111, 1110.
- sel_mode=0, sec=37, msec=42 -> d0=A4, d1=99, d2=78 (7 with dp lit), d3=B0.
- Same, msec=75 -> d2=F8 (dp off); other digits update to d0=92, d1=F8.
- sel_mode=1, hour=23, min=5, msec=10 -> d0=92, d1=C0, d2=30 (3 with dp), d3=A4. Toggle sel_mode mid-slot -> data changes on the next cycle with no change to fnd_com.
- Range check: sel_mode=0, sec=60, msec=20 -> d2=3F, d3=BF; d0/d1 show "20" (A4 on d1, C0 on d0).
- Reset mid-scan at digit_sel=2 -> same-cycle fnd_com=1111, fnd_data=FF. After release, scan restarts at 1110 with a full 4-clock slot.

Source files
------------

// File: rtl/clock_fnd_ctrl_pkg.sv
// Shared constants for the clock FND display stage: segment patterns,
// dp bit position, default scan period and per-field maxima.
package clock_fnd_ctrl_pkg;

    localparam int SCAN_COUNT_DEF = 100000;
    localparam int DP_BIT         = 7;

    // Active-low segment patterns, bits 6..0 = g..a
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    localparam logic [6:0] MSEC_MAX = 7'd99;
    localparam logic [6:0] SEC_MAX  = 7'd59;
    localparam logic [6:0] MIN_MAX  = 7'd59;
    localparam logic [6:0] HOUR_MAX = 7'd23;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic       dash;
    } field_bcd_t;

endpackage

// File: rtl/clock_fnd_decoder.sv
// One BCD digit (or dash) to an active-low 7-segment pattern.
module clock_fnd_decoder
    import clock_fnd_ctrl_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (!dash) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/clock_fnd_ctrl.sv
// Time-multiplexed 4-digit common-anode FND driver for the clock datapath:
// shows sec.msec or hour.min with a 1 Hz blinking separator on digit 2.
module clock_fnd_ctrl
    import clock_fnd_ctrl_pkg::*;
#(
    parameter int SCAN_COUNT   = SCAN_COUNT_DEF,
    parameter int BLINK_THRESH = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_mode,
    input  logic [6:0] msec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data
);

    localparam int         CNT_W   = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
    localparam logic [6:0] BLINK_T = 7'(BLINK_THRESH);

    function automatic field_bcd_t split_field(input logic [6:0] v, input logic [6:0] vmax);
        field_bcd_t f;
        f.tens = 4'(v / 7'd10);
        f.ones = 4'(v % 7'd10);
        f.dash = (v > vmax);
        return f;
    endfunction

    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       digit_sel;
    logic             scan_wrap;

    field_bcd_t low_f;
    field_bcd_t high_f;
    logic [3:0] digit_bcd;
    logic       digit_dash;
    logic [6:0] digit_seg;
    logic       dp_on;
    logic [7:0] data_nxt;

    logic [3:0] com_p1;
    logic [7:0] data_p1;

    assign scan_wrap = (scan_cnt == CNT_W'(SCAN_COUNT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt  <= '0;
            digit_sel <= 2'd0;
        end else if (scan_wrap) begin
            scan_cnt  <= '0;
            digit_sel <= digit_sel + 2'd1;
        end else begin
            scan_cnt  <= scan_cnt + CNT_W'(1);
        end
    end

    assign low_f  = sel_mode ? split_field({1'b0, min}, MIN_MAX)
                             : split_field(msec, MSEC_MAX);
    assign high_f = sel_mode ? split_field({2'b00, hour}, HOUR_MAX)
                             : split_field({1'b0, sec}, SEC_MAX);

    always_comb begin
        digit_bcd  = low_f.ones;
        digit_dash = low_f.dash;
        case (digit_sel)
            2'd0: begin
                digit_bcd  = low_f.ones;
                digit_dash = low_f.dash;
            end
            2'd1: begin
                digit_bcd  = low_f.tens;
                digit_dash = low_f.dash;
            end
            2'd2: begin
                digit_bcd  = high_f.ones;
                digit_dash = high_f.dash;
            end
            default: begin
                digit_bcd  = high_f.tens;
                digit_dash = high_f.dash;
            end
        endcase
    end

    clock_fnd_decoder u_decoder (
        .bcd  (digit_bcd),
        .dash (digit_dash),
        .seg  (digit_seg)
    );

    // Separator dp blinks off msec in both modes, always on digit 2
    assign dp_on = (digit_sel == 2'd2) && (msec < BLINK_T);

    always_comb begin
        data_nxt         = {1'b1, digit_seg};
        data_nxt[DP_BIT] = ~dp_on;
    end

    // Output register stage: p0 (digit_sel, inputs) -> p1 (pins)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            com_p1  <= 4'b1111;
            data_p1 <= 8'hFF;
        end else begin
            com_p1  <= ~(4'b0001 << digit_sel);
            data_p1 <= data_nxt;
        end
    end

    assign fnd_com  = com_p1;
    assign fnd_data = data_p1;

endmodule

// File: tb/tb_clock_fnd_ctrl.sv
// Directed scoreboard bench for clock_fnd_ctrl with a 4-cycle digit slot.
module tb_clock_fnd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel_mode;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    typedef struct {
        logic [3:0] com;
        logic [7:0] data;
    } exp_t;

    exp_t  sb[$];
    string tag_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;

    always #5 clk = ~clk;

    clock_fnd_ctrl #(
        .SCAN_COUNT   (4),
        .BLINK_THRESH (50)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel_mode (sel_mode),
        .msec     (msec),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .fnd_com  (fnd_com),
        .fnd_data (fnd_data)
    );

    // Digit slot driven out on the n-th rising edge after reset release
    function automatic logic [3:0] com_at(int n);
        logic [1:0] s;
        s = 2'(((n - 1) / 4) % 4);
        return ~(4'b0001 << s);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) cyc++;
        @(negedge clk);
    endtask

    task automatic push(string tag, logic [3:0] com, logic [7:0] data);
        exp_t e;
        e.com  = com;
        e.data = data;
        sb.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic compare();
        exp_t  e;
        string t;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: got empty queue, required an entry");
        end else begin
            e = sb.pop_front();
            t = tag_q.pop_front();
            checks++;
            assert (fnd_com === e.com) else begin
                errors++;
                $error("FAIL %s fnd_com: got %b required %b", t, fnd_com, e.com);
            end
            checks++;
            assert (fnd_data === e.data) else begin
                errors++;
                $error("FAIL %s fnd_data: got %h required %h", t, fnd_data, e.data);
            end
        end
    endtask

    task automatic expect_edge(string tag, logic [7:0] data);
        push(tag, com_at(cyc + 1), data);
        tick();
        compare();
    endtask

    task automatic expect_reset(string tag);
        push(tag, 4'b1111, 8'hFF);
        tick();
        compare();
    endtask

    // Advance until the next edge is the first of slot d
    task automatic goto_slot(int d);
        while (!((cyc % 4 == 0) && ((cyc / 4) % 4 == d))) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        sel_mode = 1'b0;
        msec     = 7'd42;
        sec      = 6'd37;
        min      = 6'd5;
        hour     = 5'd23;
        @(negedge clk);
        expect_reset("rst_hold0");
        expect_reset("rst_hold1");

        rst = 1'b1;
        cyc = 0;
        expect_edge("rel_d0_first", 8'hA4);
        tick();
        tick();
        expect_edge("rel_d0_last", 8'hA4);
        expect_edge("scan_d1", 8'h99);
        goto_slot(2); expect_edge("scan_d2_dp", 8'h78);
        goto_slot(3); expect_edge("scan_d3", 8'hB0);
        goto_slot(0); expect_edge("scan_wrap_d0", 8'hA4);

        msec = 7'd75;
        goto_slot(2); expect_edge("m75_d2_nodp", 8'hF8);
        goto_slot(3); expect_edge("m75_d3", 8'hB0);
        goto_slot(0); expect_edge("m75_d0", 8'h92);
        goto_slot(1); expect_edge("m75_d1", 8'hF8);

        msec = 7'd49;
        goto_slot(2); expect_edge("dp_thresh_49", 8'h78);
        msec = 7'd50;
        expect_edge("dp_thresh_50", 8'hF8);

        sel_mode = 1'b1; hour = 5'd23; min = 6'd5; msec = 7'd10;
        goto_slot(2); expect_edge("hm_d2_dp", 8'h30);
        goto_slot(3); expect_edge("hm_d3", 8'hA4);
        goto_slot(0); expect_edge("hm_d0", 8'h92);
        goto_slot(1); expect_edge("hm_d1", 8'hC0);
        sel_mode = 1'b0;
        expect_edge("toggle_to_sec", 8'hF9);
        sel_mode = 1'b1;
        expect_edge("toggle_to_hour", 8'hC0);

        sel_mode = 1'b0; sec = 6'd60; msec = 7'd20;
        goto_slot(2); expect_edge("sec60_d2", 8'h3F);
        goto_slot(3); expect_edge("sec60_d3", 8'hBF);
        goto_slot(0); expect_edge("sec60_d0", 8'hC0);
        goto_slot(1); expect_edge("sec60_d1", 8'hA4);

        sec = 6'd59; msec = 7'd100;
        goto_slot(0); expect_edge("ms100_d0", 8'hBF);
        goto_slot(1); expect_edge("ms100_d1", 8'hBF);
        goto_slot(2); expect_edge("sec59_d2", 8'h90);
        goto_slot(3); expect_edge("sec59_d3", 8'h92);

        sel_mode = 1'b1; hour = 5'd24; min = 6'd59; msec = 7'd99;
        goto_slot(2); expect_edge("hr24_d2", 8'hBF);
        goto_slot(3); expect_edge("hr24_d3", 8'hBF);
        goto_slot(0); expect_edge("min59_d0", 8'h90);
        goto_slot(1); expect_edge("min59_d1", 8'h92);

        hour = 5'd5; min = 6'd0; msec = 7'd10;
        goto_slot(2); expect_edge("hr5_d2_dp", 8'h12);
        goto_slot(3); expect_edge("hr5_lead0", 8'hC0);

        sel_mode = 1'b0; sec = 6'd37; msec = 7'd42;
        goto_slot(2); expect_edge("pre_rst_d2", 8'h78);
        tick();
        #2;
        rst = 1'b0;
        cyc = 0;
        push("rst_async", 4'b1111, 8'hFF);
        #1;
        compare();
        @(negedge clk);
        expect_reset("rst_mid_hold");
        rst = 1'b1;
        expect_edge("rerel_d0_first", 8'hA4);
        tick();
        tick();
        expect_edge("rerel_d0_last", 8'hA4);
        expect_edge("rerel_d1", 8'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
